// File: rtl/div_job_sequencer.sv
// Job sequencer in front of the 8-bit SRT divider: input FIFO, one-at-a-time
// issue with a start pulse, and a single-entry result slot with valid/ready.
module div_job_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_dividend,
  input  logic [7:0]               in_divisor,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     div_start,
  output logic [7:0]               div_dividend,
  output logic [7:0]               div_divisor,
  input  logic                     div_busy,
  input  logic [7:0]               div_quotient,
  input  logic [7:0]               div_remainder,
  input  logic                     div_by_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_quotient,
  output logic [7:0]               out_remainder,
  output logic                     out_div_by_zero,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 16 + TAG_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               div_start_q, div_start_d;
  logic [7:0]         div_dividend_q, div_dividend_d;
  logic [7:0]         div_divisor_q, div_divisor_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               zero_pending_q, zero_pending_d;
  logic               seen_busy_q, seen_busy_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_quotient_q, out_quotient_d;
  logic [7:0]         out_remainder_q, out_remainder_d;
  logic               out_dbz_q, out_dbz_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic               full_c, empty_c, push_c, pop_c;
  logic [ENTRY_W-1:0] head_c;

  // Next-state, FIFO bookkeeping and result-slot control
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    div_start_d     = 1'b0;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    tag_d           = tag_q;
    zero_pending_d  = zero_pending_q;
    seen_busy_d     = seen_busy_q;
    out_valid_d     = out_valid_q && !out_ready;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    out_dbz_d       = out_dbz_q;
    out_tag_d       = out_tag_q;
    pop_c           = 1'b0;

    full_c   = (level_q == LVL_W'(DEPTH));
    empty_c  = (level_q == '0);
    in_ready = !reset && !full_c;
    push_c   = in_valid && in_ready;
    head_c   = mem_q[rd_ptr_q];

    case (state_q)
      S_IDLE: begin
        // Issue only when the result slot frees up by the next edge
        if (!empty_c && (!out_valid_q || out_ready) && !div_busy) begin
          pop_c          = 1'b1;
          state_d        = S_ISSUE;
          div_start_d    = 1'b1;
          tag_d          = head_c[ENTRY_W-1:16];
          div_dividend_d = head_c[15:8];
          div_divisor_d  = head_c[7:0];
          zero_pending_d = (head_c[7:0] == 8'd0);
          seen_busy_d    = 1'b0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        seen_busy_d = seen_busy_q || div_busy;
        // Result is loaded on the edge entering CAPTURE
        if (zero_pending_q || (seen_busy_q && !div_busy)) begin
          state_d         = S_CAPTURE;
          out_valid_d     = 1'b1;
          out_quotient_d  = div_quotient;
          out_remainder_d = div_remainder;
          out_dbz_d       = div_by_zero;
          out_tag_d       = tag_q;
        end
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
    else if (!push_c && pop_c) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      div_start_q     <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      tag_q           <= '0;
      zero_pending_q  <= 1'b0;
      seen_busy_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      out_dbz_q       <= 1'b0;
      out_tag_q       <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      div_start_q     <= div_start_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      tag_q           <= tag_d;
      zero_pending_q  <= zero_pending_d;
      seen_busy_q     <= seen_busy_d;
      out_valid_q     <= out_valid_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      out_dbz_q       <= out_dbz_d;
      out_tag_q       <= out_tag_d;
    end
  end

  // Storage needs no reset: the level and pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {in_tag, in_dividend, in_divisor};
  end

  assign div_start       = div_start_q;
  assign div_dividend    = div_dividend_q;
  assign div_divisor     = div_divisor_q;
  assign out_valid       = out_valid_q;
  assign out_quotient    = out_quotient_q;
  assign out_remainder   = out_remainder_q;
  assign out_div_by_zero = out_dbz_q;
  assign out_tag         = out_tag_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Bench for div_job_sequencer with a cycle-accurate behavioural divider.
module tb_div_job_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_dividend, in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             div_start;
  logic [7:0]       div_dividend, div_divisor;
  logic             div_busy;
  logic [7:0]       div_quotient, div_remainder;
  logic             div_by_zero;
  logic             out_valid, out_ready;
  logic [7:0]       out_quotient, out_remainder;
  logic             out_div_by_zero;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       fifo_level;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int viol_cnt = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  div_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_by_zero(out_div_by_zero), .out_tag(out_tag),
    .fifo_level(fifo_level)
  );

  // Divider: busy rises the edge after start, stays 10 cycles, results on fall
  logic [3:0] m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      div_busy <= 1'b0; m_cnt <= 4'd0;
      div_quotient <= 8'd0; div_remainder <= 8'd0; div_by_zero <= 1'b0;
    end else if (div_start) begin
      if (div_divisor == 8'd0) begin
        div_quotient <= 8'hFF; div_remainder <= 8'hFF; div_by_zero <= 1'b1;
      end else begin
        div_busy <= 1'b1; m_cnt <= 4'd10; div_by_zero <= 1'b0;
      end
    end else if (div_busy) begin
      if (m_cnt == 4'd1) begin
        div_busy      <= 1'b0;
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end else begin
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (div_start && div_busy) viol_cnt++;
    if (out_valid) ov_cnt++;
  end

  typedef struct {
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [1:0] tag;
    int         q;
    int         r;
    int         dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("push_timeout", 0, 1);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_res(input string name, input int q, input int r, input int dz, input int t);
    check({name, "_q"},   int'(out_quotient), q);
    check({name, "_r"},   int'(out_remainder), r);
    check({name, "_dz"},  int'(out_div_by_zero), dz);
    check({name, "_tag"}, int'(out_tag), t);
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int lat, s0, o0, bad;
    vecs[0] = '{8'd200, 8'd7,  2'd1, 28,  4,   0, 13};
    vecs[1] = '{8'd55,  8'd0,  2'd2, 255, 255, 1, 3};
    vecs[2] = '{8'd9,   8'd3,  2'd3, 3,   0,   0, 13};
    vecs[3] = '{8'd0,   8'd1,  2'd0, 0,   0,   0, 13};
    vecs[4] = '{8'd255, 8'd16, 2'd1, 15,  15,  0, 13};

    reset = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_forced", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_div_start", int'(div_start), 0);
    check("rst_level", int'(fifo_level), 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Table: single jobs with latency, results and start-pulse count
    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      push(vecs[i].dividend, vecs[i].divisor, vecs[i].tag);
      wait_out(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check_res($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, int'(vecs[i].tag));
      check($sformatf("v%0d_starts", i), start_cnt - s0, 1);
      pop_out();
    end

    // FIFO fill with the result slot blocked
    push(8'd255, 8'd1, 2'd0);
    push(8'd0, 8'd5, 2'd1);
    push(8'd17, 8'd17, 2'd2);
    push(8'd100, 8'd200, 2'd3);
    push(8'd8, 8'd3, 2'd0);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_level", int'(fifo_level), 4);
    wait_out(lat);
    check("fill_in_ready_held", int'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int qs[5], rs[5];
      qs = '{255, 0, 1, 0, 2};
      rs = '{0, 0, 0, 100, 2};
      wait_out(lat);
      check_res($sformatf("fill%0d", k), qs[k], rs[k], 0, k % 4);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;

    // Backpressure: held result blocks further issue
    push(8'd50, 8'd5, 2'd1);
    push(8'd61, 8'd6, 2'd2);
    wait_out(lat);
    s0 = start_cnt;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (!out_valid || out_quotient != 8'd10 || out_remainder != 8'd0 || out_tag != 2'd1)
        bad++;
    end
    check("bp_stable_bad_cycles", bad, 0);
    check("bp_no_start", start_cnt - s0, 0);
    check("bp_level", int'(fifo_level), 1);
    pop_out();
    check("bp_release_start", int'(div_start), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    wait_out(lat);
    check("bp_second_lat", lat, 12);
    check_res("bp2", 10, 1, 0, 2);
    pop_out();

    // Simultaneous push and pop at level 2
    push(8'd10, 8'd2, 2'd0);
    wait_out(lat);
    push(8'd21, 8'd4, 2'd1);
    push(8'd31, 8'd5, 2'd2);
    check("pp_level_before", int'(fifo_level), 2);
    in_valid = 1'b1; in_dividend = 8'd40; in_divisor = 8'd8; in_tag = 2'd3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pp_level_after", int'(fifo_level), 2);
    check("pp_start", int'(div_start), 1);
    for (int k = 0; k < 3; k++) begin
      int qs[3], rs[3];
      qs = '{5, 6, 5};
      rs = '{1, 1, 0};
      wait_out(lat);
      check_res($sformatf("pp%0d", k), qs[k], rs[k], 0, k + 1);
      @(posedge clk); #1;
    end

    // Pointer wrap over 3*DEPTH jobs
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++)
          push(8'(i * 20 + 5), 8'(i + 2), 2'(i % 4));
      end
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          int l;
          wait_out(l);
          check($sformatf("wrap%0d_q", i), int'(out_quotient), (i * 20 + 5) / (i + 2));
          check($sformatf("wrap%0d_tag", i), int'(out_tag), i % 4);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b0;

    // Reset in WAIT with three jobs queued
    out_ready = 1'b1;
    push(8'd90, 8'd9, 2'd0);
    push(8'd91, 8'd9, 2'd1);
    push(8'd92, 8'd9, 2'd2);
    push(8'd93, 8'd9, 2'd3);
    check("rw_level", int'(fifo_level), 3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rw_out_valid", int'(out_valid), 0);
    check("rw_div_start", int'(div_start), 0);
    check("rw_div_operands", int'({div_dividend, div_divisor}), 0);
    check("rw_out_data", int'({out_quotient, out_remainder, out_div_by_zero, out_tag}), 0);
    check("rw_level0", int'(fifo_level), 0);
    check("rw_in_ready", int'(in_ready), 1);
    o0 = ov_cnt;
    s0 = start_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("rw_no_stale_result", ov_cnt - o0, 0);
    check("rw_no_start", start_cnt - s0, 0);
    out_ready = 1'b0;

    check("start_while_busy", viol_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
